// File: rtl/rf_pkg.sv
// Shared definitions for the register-file port controller: sizing defaults,
// FSM state encoding and the address-to-one-hot decoder.
package rf_pkg;

  localparam int RF_NREG = 8;
  localparam int RF_AW   = 3;
  localparam int RF_DW   = 8;

  // Decoder width ceiling; callers cast the result down to their own NREG.
  localparam int RF_MAX_AW   = 8;
  localparam int RF_MAX_NREG = 256;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_e;

  function automatic logic [RF_MAX_NREG-1:0] onehot(input logic [RF_MAX_AW-1:0] addr);
    return RF_MAX_NREG'(1) << addr;
  endfunction

endpackage

// File: rtl/rr_arb.sv
// Combinational round-robin pick: the first requester found scanning upward
// from ptr_i (wrapping at NREQ) wins.
module rr_arb #(
  parameter int NREQ = 4,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [PW-1:0]   ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [PW-1:0]   idx_o,
  output logic            any_o
);

  // Scan requesters in priority order starting at the pointer.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      int  raw;
      int  cand;
      logic hit;
      raw        = int'(ptr_i) + i;
      cand       = (raw >= NREQ) ? (raw - NREQ) : raw;
      hit        = ~any_o & req_i[cand];
      gnt_o[cand] = hit;
      idx_o      = hit ? PW'(cand) : idx_o;
      any_o      = any_o | hit;
    end
  end

endmodule

// File: rtl/rf_port_ctrl.sv
// Register-file port controller: round-robin shared write port with a
// two-state WRITE FSM, plus one-hot decode of the two tri-state read ports.
module rf_port_ctrl
  import rf_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int NREG = RF_NREG,
  parameter int AW   = RF_AW,
  parameter int DW   = RF_DW
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [NREQ-1:0]     i_wrReq,
  input  logic [NREQ*AW-1:0]  i_wrAddr,
  input  logic [NREQ*DW-1:0]  i_wrData,
  output logic [NREQ-1:0]     o_wrGnt,
  output logic [NREG-1:0]     o_writeEn,
  output logic [DW-1:0]       o_wrData,
  input  logic                i_rdEn1,
  input  logic                i_rdEn2,
  input  logic [AW-1:0]       i_rdAddr1,
  input  logic [AW-1:0]       i_rdAddr2,
  output logic [NREG-1:0]     o_readEn1,
  output logic [NREG-1:0]     o_readEn2,
  output logic                o_rdHazard1,
  output logic                o_rdHazard2
);

  localparam int PW = $clog2(NREQ);

  state_e            state_q;
  logic [PW-1:0]     ptr_q;
  logic [NREQ-1:0]   gnt_q;
  logic [NREG-1:0]   wen_q;
  logic [DW-1:0]     wdata_q;
  logic [AW-1:0]     waddr_q;

  logic [NREQ-1:0]   arb_gnt;
  logic [PW-1:0]     arb_idx;
  logic              arb_any;

  logic [AW-1:0]     sel_addr_d;
  logic [DW-1:0]     sel_data_d;
  logic [NREG-1:0]   wen_d;
  logic [PW-1:0]     ptr_d;

  logic              rd_en1_s;
  logic              rd_en2_s;

  rr_arb #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_arb (
    .req_i (i_wrReq),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .any_o (arb_any)
  );

  // Winner's address/data, its row enable, and the pointer just past it.
  always_comb begin
    sel_addr_d = i_wrAddr[int'(arb_idx)*AW +: AW];
    sel_data_d = i_wrData[int'(arb_idx)*DW +: DW];
    wen_d      = NREG'(onehot(RF_MAX_AW'(sel_addr_d)));
    ptr_d      = (int'(arb_idx) == NREQ - 1) ? '0 : (arb_idx + PW'(1));
  end

  // Write FSM: grant in IDLE, hold the write for exactly one WRITE cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      wen_q   <= '0;
      wdata_q <= '0;
      waddr_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (arb_any) begin
            state_q <= WRITE;
            gnt_q   <= arb_gnt;
            wen_q   <= wen_d;
            wdata_q <= sel_data_d;
            waddr_q <= sel_addr_d;
            ptr_q   <= ptr_d;
          end else begin
            state_q <= IDLE;
            gnt_q   <= '0;
            wen_q   <= '0;
            wdata_q <= '0;
          end
        end
        WRITE: begin
          state_q <= IDLE;
          gnt_q   <= '0;
          wen_q   <= '0;
          wdata_q <= '0;
        end
        default: begin
          state_q <= IDLE;
          ptr_q   <= '0;
          gnt_q   <= '0;
          wen_q   <= '0;
          wdata_q <= '0;
        end
      endcase
    end
  end

  assign o_wrGnt   = gnt_q;
  assign o_writeEn = wen_q;
  assign o_wrData  = wdata_q;

  // Read decode; hazard flags a read of the row being written this cycle
  // (the array still returns the old value then).
  always_comb begin
    rd_en1_s    = i_rdEn1 & ~i_rst;
    rd_en2_s    = i_rdEn2 & ~i_rst;
    o_readEn1   = rd_en1_s ? NREG'(onehot(RF_MAX_AW'(i_rdAddr1))) : '0;
    o_readEn2   = rd_en2_s ? NREG'(onehot(RF_MAX_AW'(i_rdAddr2))) : '0;
    o_rdHazard1 = rd_en1_s & (state_q == WRITE) & (i_rdAddr1 == waddr_q);
    o_rdHazard2 = rd_en2_s & (state_q == WRITE) & (i_rdAddr2 == waddr_q);
  end

endmodule

// File: tb/tb_rf_port_ctrl.sv
// Scoreboard bench for rf_port_ctrl: a behavioural arbiter/register model
// predicts each write, a monitor compares what the DUT presents.
module tb_rf_port_ctrl;

  localparam int NREQ = 4;
  localparam int NREG = 8;
  localparam int AW   = 3;
  localparam int DW   = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst;
  logic [NREQ-1:0]     wr_req;
  logic [NREQ*AW-1:0]  wr_addr;
  logic [NREQ*DW-1:0]  wr_data;
  logic [NREQ-1:0]     o_wrGnt;
  logic [NREG-1:0]     o_writeEn;
  logic [DW-1:0]       o_wrData;
  logic                rd_en1, rd_en2;
  logic [AW-1:0]       rd_addr1, rd_addr2;
  logic [NREG-1:0]     o_readEn1, o_readEn2;
  logic                o_rdHazard1, o_rdHazard2;

  rf_port_ctrl #(.NREQ(NREQ), .NREG(NREG), .AW(AW), .DW(DW)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_wrReq(wr_req), .i_wrAddr(wr_addr), .i_wrData(wr_data),
    .o_wrGnt(o_wrGnt), .o_writeEn(o_writeEn), .o_wrData(o_wrData),
    .i_rdEn1(rd_en1), .i_rdEn2(rd_en2),
    .i_rdAddr1(rd_addr1), .i_rdAddr2(rd_addr2),
    .o_readEn1(o_readEn1), .o_readEn2(o_readEn2),
    .o_rdHazard1(o_rdHazard1), .o_rdHazard2(o_rdHazard2)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // The register array the controller drives (tri-state read emulated as an OR).
  logic [DW-1:0] arr [NREG];
  always @(posedge clk)
    if (!rst)
      for (int r = 0; r < NREG; r++)
        if (o_writeEn[r]) arr[r] <= o_wrData;

  function automatic logic [DW-1:0] rd_bus(input logic [NREG-1:0] en);
    logic [DW-1:0] v = '0;
    for (int r = 0; r < NREG; r++) if (en[r]) v |= arr[r];
    return v;
  endfunction

  // Reference model: busy flag, rotating pointer, register contents.
  typedef struct { int cyc; int idx; int addr; int data; } exp_t;
  exp_t          q[$];
  int            cyc = 0;
  bit            m_busy = 0;
  int            m_ptr = 0;
  int            m_addr = 0;
  int            m_data = 0;
  bit            m_rst_last = 0;
  logic [DW-1:0] m_mem [NREG];

  always @(posedge clk) begin
    cyc++;
    m_rst_last = rst;
    if (rst) begin
      m_busy = 0;
      m_ptr  = 0;
    end else if (m_busy) begin
      m_mem[m_addr] = m_data[DW-1:0];
      m_busy = 0;
    end else if (wr_req != 0) begin
      for (int i = 0; i < NREQ; i++) begin
        int k;
        k = (m_ptr + i) % NREQ;
        if (!m_busy && wr_req[k]) begin
          m_busy = 1;
          m_addr = int'(wr_addr[k*AW +: AW]);
          m_data = int'(wr_data[k*DW +: DW]);
          m_ptr  = (k + 1) % NREQ;
          q.push_back('{cyc: cyc, idx: k, addr: m_addr, data: m_data});
        end
      end
    end
  end

  exp_t mon_e;
  int   hz_cnt = 0;

  // Monitor: compare presented writes against the queue and reads every cycle.
  always @(negedge clk) begin
    if (m_rst_last) begin
      check("rst_gnt", o_wrGnt, 0);
      check("rst_wen", o_writeEn, 0);
      check("rst_wdata", o_wrData, 0);
    end else if (o_wrGnt != 0 || o_writeEn != 0) begin
      if (q.size() == 0) begin
        check("unexpected_write", {o_wrGnt, o_writeEn}, 0);
      end else begin
        mon_e = q.pop_front();
        check("write_cycle", cyc, mon_e.cyc);
        check("write_gnt", o_wrGnt, 64'(1) << mon_e.idx);
        check("write_en", o_writeEn, 64'(1) << mon_e.addr);
        check("write_data", o_wrData, mon_e.data);
      end
    end else if (q.size() != 0 && q[0].cyc <= cyc) begin
      void'(q.pop_front());
      check("missing_write", 0, 1);
    end
    check("readEn1", o_readEn1, (!rst && rd_en1) ? (64'(1) << rd_addr1) : 64'(0));
    check("readEn2", o_readEn2, (!rst && rd_en2) ? (64'(1) << rd_addr2) : 64'(0));
    check("hazard1", o_rdHazard1, !rst && m_busy && rd_en1 && (int'(rd_addr1) == m_addr));
    check("hazard2", o_rdHazard2, !rst && m_busy && rd_en2 && (int'(rd_addr2) == m_addr));
    if (!rst && rd_en1) check("rdata1", rd_bus(o_readEn1), m_mem[rd_addr1]);
    if (!rst && rd_en2) check("rdata2", rd_bus(o_readEn2), m_mem[rd_addr2]);
    if (o_rdHazard1) hz_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_any(input int budget);
    for (int i = 0; i < budget && o_wrGnt == 0; i++) tick();
    check("grant_timeout", o_wrGnt != 0, 1);
  endtask

  task automatic new_req(input int k);
    wr_req[k] = 1'b1;
    wr_addr[k*AW +: AW] = AW'($urandom);
    wr_data[k*DW +: DW] = DW'($urandom);
  endtask

  int gidx[$];
  int gcyc[$];
  logic [DW-1:0] old5;
  int lo;

  initial begin : stim
    for (int r = 0; r < NREG; r++) begin
      arr[r]   = '0;
      m_mem[r] = '0;
    end
    rst = 1'b1;
    wr_req = NREQ'($urandom_range(1, (1 << NREQ) - 1));
    wr_addr = NREQ*AW'($urandom);
    wr_data = {$urandom, $urandom};
    rd_en1 = 1'b0; rd_en2 = 1'b0; rd_addr1 = '0; rd_addr2 = '0;
    tick(); tick();

    // First grant after reset goes to the lowest requester.
    rst = 1'b0;
    lo = 0;
    for (int k = NREQ - 1; k >= 0; k--) if (wr_req[k]) lo = k;
    wait_any(4);
    check("first_grant", o_wrGnt, 64'(1) << lo);
    wr_req = '0;
    tick(); tick();

    // Single write from requester 2 with a hazarding read.
    old5 = m_mem[5];
    wr_req = 4'b0100;
    wr_addr[2*AW +: AW] = 3'd5;
    wr_data[2*DW +: DW] = 8'hA5;
    wait_any(4);
    check("single_gnt", o_wrGnt, 4'b0100);
    check("single_wen", o_writeEn, 8'b0010_0000);
    check("single_data", o_wrData, 8'hA5);
    wr_req = '0;
    rd_en1 = 1'b1; rd_addr1 = 3'd5;
    #1;
    check("hz_during_write", o_rdHazard1, 1);
    check("old_value_read", rd_bus(o_readEn1), old5);
    tick();
    check("hz_after_write", o_rdHazard1, 0);
    check("new_value_read", rd_bus(o_readEn1), 8'hA5);
    check("wen_one_cycle", o_writeEn, 0);

    // Read decode corners.
    rd_en1 = 1'b0;
    #1;
    check("rd1_disabled", o_readEn1, 0);
    rd_en1 = 1'b1; rd_en2 = 1'b1; rd_addr1 = 3'd7; rd_addr2 = 3'd7;
    #1;
    check("rd1_addr7", o_readEn1, 8'b1000_0000);
    check("rd2_addr7", o_readEn2, 8'b1000_0000);
    tick();

    // Contention from a clean pointer: rotation 0,1,2,3,0 every 2 cycles.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < NREQ; k++) new_req(k);
    for (int i = 0; i < 12; i++) begin
      tick();
      if (o_wrGnt != 0) begin
        for (int k = 0; k < NREQ; k++) if (o_wrGnt[k]) begin
          gidx.push_back(k);
          gcyc.push_back(cyc);
          new_req(k);
        end
      end
    end
    check("contention_count", gidx.size() >= 5, 1);
    if (gidx.size() >= 5) begin
      for (int i = 0; i < 5; i++) check("contention_order", gidx[i], i % NREQ);
      for (int i = 1; i < 5; i++) check("contention_spacing", gcyc[i] - gcyc[i-1], 2);
    end

    // Reset landing on the WRITE cycle aborts it and clears the pointer.
    wait_any(4);
    rst = 1'b1;
    tick();
    check("abort_wen", o_writeEn, 0);
    check("abort_gnt", o_wrGnt, 0);
    rst = 1'b0;
    tick();
    check("post_abort_ptr0", o_wrGnt, 4'b0001);
    new_req(0);

    // Randomised traffic with well-behaved requesters.
    for (int i = 0; i < 400; i++) begin
      tick();
      for (int k = 0; k < NREQ; k++) begin
        if (o_wrGnt[k]) begin
          if ($urandom_range(0, 1) == 0) new_req(k);
          else wr_req[k] = 1'b0;
        end else if (!wr_req[k]) begin
          if ($urandom_range(0, 2) == 0) new_req(k);
        end else if ($urandom_range(0, 31) == 0) begin
          wr_req[k] = 1'b0;
        end
      end
      rd_en1 = 1'($urandom); rd_addr1 = AW'($urandom);
      rd_en2 = 1'($urandom); rd_addr2 = AW'($urandom);
      rst = ($urandom_range(0, 99) == 0);
    end

    rst = 1'b0;
    wr_req = '0;
    tick(); tick(); tick();
    check("queue_drained", q.size(), 0);
    check("hazard_seen", hz_cnt > 0, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/rf_port_ctrl.md
# rf_port_ctrl

Port controller for the register file built from the cell array in this design: each cell has one write enable and two tri-state read enables. The block shares the single write port among NREQ requesters with a round-robin arbiter, then drives the one-hot per-register write enables and the write data. It also decodes the two read addresses into one-hot read enables, so that at most one cell drives each shared read bus. It sits between the requesting datapath units and the register array.

## Interface
Parameters:
- NREQ, 4, number of write requesters (2..8)
- NREG, 8, number of registers (power of 2)
- AW, 3, register address width, log2(NREG)
- DW, 8, register data width

Ports:
- i_clk, input, 1, the single clock; all state updates on the rising edge
- i_rst, input, 1, reset; synchronous, active-high
- i_wrReq, input, NREQ, per-requester write request, level
- i_wrAddr, input, NREQ*AW, packed addresses; requester k occupies bits [k*AW +: AW]
- i_wrData, input, NREQ*DW, packed data; requester k occupies bits [k*DW +: DW]
- o_wrGnt, output, NREQ, one-hot grant pulse, registered
- o_writeEn, output, NREG, one-hot write enable to the register rows, registered
- o_wrData, output, DW, data bus to the register array, registered
- i_rdEn1, i_rdEn2, input, 1 each, read port enables
- i_rdAddr1, i_rdAddr2, input, AW each, read addresses
- o_readEn1, o_readEn2, output, NREG each, one-hot read enables
- o_rdHazard1, o_rdHazard2, output, 1 each, the read address matches the write in progress

## Operation
- FSM has two states.
  - IDLE: if any i_wrReq bit is set, pick a winner round-robin starting at ptr. At the edge, go to WRITE and register:
    - o_wrGnt = onehot(winner)
    - o_writeEn = onehot(i_wrAddr[winner])
    - o_wrData = i_wrData[winner]
    - ptr = (winner+1) mod NREQ
  - IDLE with no request: stay in IDLE with all registered outputs at 0.
  - WRITE: lasts exactly one cycle. The cells latch o_wrData at the edge that ends this cycle. At that edge the FSM returns to IDLE and clears o_wrGnt and o_writeEn.
  - No arbitration happens in WRITE. The granted requester sees o_wrGnt during WRITE and must drop or change its request by the next edge.
- Handshake: a requester holds i_wrReq, its address and its data stable until it samples o_wrGnt high. Dropping a request before the grant is legal; that write is lost and no error is flagged.
- Maximum write throughput is one write per 2 cycles.
- Fairness: with all NREQ requesting continuously, grants rotate k, k+1, … mod NREQ. No requester waits more than NREQ writes.
- Read decode is combinational: o_readEn1 = i_rdEn1 ? onehot(i_rdAddr1) : 0. Port 2 is identical. Both read ports may select the same register.
- o_rdHazardN = (state==WRITE) & i_rdEnN & (i_rdAddrN == latched write address). In that cycle the read returns the old value. The hazard flag is informational only; no bypass is performed.
- At most one bit of o_writeEn, o_readEn1 and o_readEn2 is ever set.

## Timing
- Reset (i_rst high at an edge):
  - state=IDLE, ptr=0
  - o_wrGnt=0, o_writeEn=0, o_wrData=0
- While i_rst is high, o_readEn1/2 and o_rdHazard1/2 are forced to 0.
- Reset during WRITE aborts the write: o_writeEn is 0 after that edge. The register array still samples at that edge, so the abort is guaranteed only if the array is also held in reset.
- Latency from request to write:
  - request sampled in IDLE at edge t
  - grant and writeEn high in cycle t..t+1
  - register updated at edge t+1
  - value readable from cycle t+1 onward
- Request arrival while in WRITE: the request is first considered at the edge that leaves the following IDLE cycle. Earliest back-to-back grants are 2 cycles apart.
- ptr wraps from NREQ-1 to 0.

## Structure
- Shared package rf_pkg holds:
  - NREG, AW, DW defaults
  - state encoding IDLE=1'b0, WRITE=1'b1
  - function onehot(addr) returning NREG bits
- Sub-module rr_arb: pure combinational round-robin pick.
  - Inputs: req[NREQ], ptr
  - Outputs: gnt one-hot, idx, any
- rf_port_ctrl instantiates rr_arb. It owns the FSM, ptr, output registers and read decode.

## Test plan
- Reset: hold i_rst for 2 cycles with random requests -> all outputs 0. The first grant after release goes to the lowest requesting index at or above 0.
- Single write: requester 2 requests addr 5, data 8'hA5 -> o_wrGnt=4'b0100 and o_writeEn=8'b0010_0000, o_wrData=8'hA5 for exactly one cycle. The register reads A5 afterwards.
- Contention: all 4 request continuously -> grant order 0,1,2,3,0 with a 2-cycle spacing. There is never a double grant.
- Hazard: read port 1 addr 5 with i_rdEn1=1 during the write cycle to addr 5 -> o_rdHazard1=1 and the old value is read. The next cycle gives the new value and o_rdHazard1=0.
- Read decode: i_rdEn1=0 -> o_readEn1=0. Both ports addr 7 -> both equal 8'b1000_0000.
- Reset mid-WRITE: assert i_rst in the WRITE cycle -> o_writeEn=0 after the edge and ptr=0.
